fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction-fetch stage. It drives the PC's pause and redirect inputs, runs the request/acknowledge handshake with a variable-latency instruction memory, and generates the IF/ID hold/flush and ID/EX bubble controls. It resolves collisions between EX-stage redirects, ID-stage load-use hazards and outstanding fetches. It sits between the fetch stage, the instruction memory port and the hazard logic.

## Interface
- TIMEOUT, 15: wait cycles without `imem_ack` before the fetch is declared failed; range 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- jump_flag  in  1  EX-stage redirect request; valid for one cycle.
- ex_npc  in  32  redirect target, qualified by `jump_flag`.
- load_use_hazard  in  1  ID-stage load-use hazard; lasts one cycle.
- imem_ack  in  1  instruction memory has returned data for the current request.
- imem_req  out  1  fetch request; the address is the current PC.
- pause_flag  out  1  holds the PC.
- jump_out  out  1  redirect strobe to the fetch stage.
- npc_out  out  32  redirect target to the fetch stage.
- fetch_valid  out  1  the returned instruction is written into IF/ID as valid.
- if_id_hold  out  1  IF/ID keeps its current contents.
- if_id_flush  out  1  IF/ID is loaded with a bubble.
- id_ex_flush  out  1  ID/EX is loaded with a bubble.
- timeout_err  out  1  sticky fetch-timeout error.

## Operation
- States: IDLE, FETCH, DISCARD, ERROR.
- Behaviour during and after reset:
  - Reset enters IDLE.
  - In IDLE all outputs are 0, except `pause_flag`=1.
  - IDLE moves to FETCH unconditionally on the next edge.
- FETCH behaviour:
  - `imem_req`=1.
  - Default when `imem_ack`=0: `pause_flag`=1, `if_id_flush`=1 (bubble), and the wait counter increments.
- Priority in FETCH is jump > load-use > ack:
  - **jump_flag=1**: `if_id_flush`=1 and `id_ex_flush`=1. Any acknowledged data is dropped (`fetch_valid`=0).
    - With `imem_ack`=1: `jump_out`=1, `npc_out`=`ex_npc`, `pause_flag`=0, and the state stays FETCH.
    - With `imem_ack`=0: `ex_npc` is latched into `redir_pc`, `pause_flag`=1, and the state goes to DISCARD.
  - **load_use_hazard=1**: `pause_flag`=1, `if_id_hold`=1, `id_ex_flush`=1, `fetch_valid`=0. Acknowledged data is dropped and the same PC is fetched again next cycle.
  - **imem_ack=1** with no other condition: `fetch_valid`=1, `pause_flag`=0 (PC advances by 4), and the wait counter clears.
- DISCARD behaviour:
  - `imem_req` stays at 1, because a request is never withdrawn.
  - `pause_flag`=1 and `if_id_flush`=1.
  - On `imem_ack`: the data is dropped, `jump_out`=1, `npc_out`=`redir_pc`, `pause_flag`=0, and the state goes to FETCH.
  - A new `jump_flag` arriving in DISCARD overwrites `redir_pc`; the newest target wins.
  - If a new `jump_flag` arrives in the same cycle as `imem_ack`, `ex_npc` is output directly.
  - `load_use_hazard` in DISCARD asserts `id_ex_flush` only.
- Timeout:
  - The wait counter is 8 bits and counts in FETCH and DISCARD.
  - When it reaches TIMEOUT with no ack, the state goes to ERROR.
- ERROR behaviour:
  - `imem_req`=0, `pause_flag`=1, `if_id_flush`=1, `timeout_err`=1.
  - Only reset leaves ERROR.
- `npc_out` is 0 whenever `jump_out`=0.

## Timing
- All outputs are combinational from state, `redir_pc` and the current inputs. The PC and pipeline registers act on the next edge.
- Fetch latency: the first `imem_req` occurs 1 cycle after reset is released. The best-case throughput is one instruction per cycle (ack in the same cycle).
- Redirect latency:
  - 0 cycles when the ack is coincident.
  - Otherwise the redirect is issued in the cycle the outstanding ack returns.
- Load-use costs exactly one cycle of PC stall.
- The wait counter clears on every accepted ack and on every state entry into FETCH.
- Asserting reset mid-transaction:
  - Outputs clear immediately (asynchronously).
  - A pending `redir_pc` is lost.
  - A late `imem_ack` seen in IDLE is ignored.

## Structure
- Shared package `fetch_pkg`: the state enum (IDLE/FETCH/DISCARD/ERROR), the wait-counter width constant, and the 32-bit address width constant.
- One natural sub-module, `fetch_wait_timer`: an 8-bit counter with clear/enable inputs and a `>= TIMEOUT` compare output.
- Registers: state, `redir_pc[31:0]`, wait counter. Everything else is combinational.

## Test plan
- Zero-wait fetch stream: reset release, then `imem_ack` tied to 1 → first `imem_req` at cycle 1; `fetch_valid`=1 every cycle after that; `pause_flag`=0.
- 3-cycle memory latency: ack every 3rd cycle → `pause_flag`=1 and `if_id_flush`=1 for 2 cycles, then 1 cycle with `fetch_valid`=1; the PC advances by 4 per ack.
- Jump during wait: `jump_flag`=1 with `ex_npc`=0x0000_0100 while no ack, ack arrives 2 cycles later → both flushes in the jump cycle; the state goes to DISCARD; at the ack, `jump_out`=1, `npc_out`=0x100 and `fetch_valid`=0.
- Jump coincident with load-use and ack: → `jump_out`=1, `if_id_hold`=0, both flushes=1; no stall.
- Load-use with ack: → `pause_flag`=1, `if_id_hold`=1, `id_ex_flush`=1 for exactly one cycle; the same PC is requested again and accepted next cycle.
- Timeout and reset: TIMEOUT=4 with the ack held low → ERROR after 4 wait cycles, `imem_req`=0, `timeout_err` sticky; asserting reset (`rst`=0) clears it asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch sequencing controller.
package fetch_pkg;

  localparam int WAIT_W = 8;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    ERROR   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// Wait-cycle counter for an outstanding fetch. `hit` flags that the count taken
// this cycle brings the counter to TIMEOUT.
module fetch_wait_timer
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [WAIT_W-1:0] count,
  output logic              hit
);

  localparam logic [WAIT_W:0] LIMIT = (WAIT_W + 1)'(TIMEOUT);

  logic [WAIT_W:0] count_inc;

  // One extra bit so the compare cannot wrap when TIMEOUT is 255.
  assign count_inc = {1'b0, count} + {{WAIT_W{1'b0}}, 1'b1};
  assign hit       = en && (count_inc >= LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc[WAIT_W-1:0];
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC pause/redirect, imem request/ack handshake,
// IF/ID hold/flush and ID/EX bubble generation, fetch timeout detection.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] ex_npc,
  input  logic              load_use_hazard,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic              pause_flag,
  output logic              jump_out,
  output logic [ADDR_W-1:0] npc_out,
  output logic              fetch_valid,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              timeout_err,
  output fetch_state_t      dbg_state,
  output logic [WAIT_W-1:0] dbg_wait
);

  // Handshake: imem_req stays high from issue until the cycle imem_ack is
  // seen; the request is never withdrawn, even when its data will be dropped.

  fetch_state_t      state, next_state;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_load;
  logic              timer_clr, timer_en, timer_hit;

  fetch_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .en    (timer_en),
    .count (dbg_wait),
    .hit   (timer_hit)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      redir_pc <= '0;
    end else begin
      state <= next_state;
      if (redir_load) redir_pc <= ex_npc;
    end
  end

  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    pause_flag  = 1'b1;
    jump_out    = 1'b0;
    npc_out     = '0;
    fetch_valid = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    timeout_err = 1'b0;
    redir_load  = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    unique case (state)
      IDLE: begin
        timer_clr  = 1'b1;
        next_state = FETCH;
      end

      FETCH: begin
        imem_req  = 1'b1;
        timer_clr = imem_ack;
        timer_en  = !imem_ack;
        if (jump_flag) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (imem_ack) begin
            jump_out   = 1'b1;
            npc_out    = ex_npc;
            pause_flag = 1'b0;
          end else begin
            // Redirect must wait for the outstanding response to drain.
            redir_load = 1'b1;
            next_state = timer_hit ? ERROR : DISCARD;
          end
        end else if (load_use_hazard) begin
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
          if (timer_hit) next_state = ERROR;
        end else if (imem_ack) begin
          fetch_valid = 1'b1;
          pause_flag  = 1'b0;
        end else begin
          if_id_flush = 1'b1;
          if (timer_hit) next_state = ERROR;
        end
      end

      DISCARD: begin
        imem_req    = 1'b1;
        if_id_flush = 1'b1;
        if (jump_flag) begin
          redir_load  = 1'b1;
          id_ex_flush = 1'b1;
        end
        if (load_use_hazard) id_ex_flush = 1'b1;
        if (imem_ack) begin
          // A jump arriving with the ack bypasses redir_pc: newest target wins.
          jump_out   = 1'b1;
          npc_out    = jump_flag ? ex_npc : redir_pc;
          pause_flag = 1'b0;
          timer_clr  = 1'b1;
          next_state = FETCH;
        end else begin
          timer_en = 1'b1;
          if (timer_hit) next_state = ERROR;
        end
      end

      ERROR: begin
        if_id_flush = 1'b1;
        timeout_err = 1'b1;
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one-cycle vector table plus hand-written reset sequences.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              jump_flag = 1'b0;
  logic [31:0]       ex_npc = '0;
  logic              load_use_hazard = 1'b0;
  logic              imem_ack = 1'b0;
  logic              imem_req, pause_flag, jump_out, fetch_valid;
  logic              if_id_hold, if_id_flush, id_ex_flush, timeout_err;
  logic [31:0]       npc_out;
  fetch_state_t      dbg_state;
  logic [WAIT_W-1:0] dbg_wait;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_flag       (jump_flag),
    .ex_npc          (ex_npc),
    .load_use_hazard (load_use_hazard),
    .imem_ack        (imem_ack),
    .imem_req        (imem_req),
    .pause_flag      (pause_flag),
    .jump_out        (jump_out),
    .npc_out         (npc_out),
    .fetch_valid     (fetch_valid),
    .if_id_hold      (if_id_hold),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .timeout_err     (timeout_err),
    .dbg_state       (dbg_state),
    .dbg_wait        (dbg_wait)
  );

  always #5 clk = ~clk;

  // Flag order: req pause jump_out fetch_valid hold if_flush ex_flush timeout_err
  localparam logic [7:0] F_IDLE  = 8'b0100_0000;
  localparam logic [7:0] F_ACK   = 8'b1001_0000;
  localparam logic [7:0] F_WAIT  = 8'b1100_0100;
  localparam logic [7:0] F_JWAIT = 8'b1100_0110;
  localparam logic [7:0] F_DACK  = 8'b1010_0100;
  localparam logic [7:0] F_JACK  = 8'b1010_0110;
  localparam logic [7:0] F_LUACK = 8'b1100_1010;
  localparam logic [7:0] F_ERR   = 8'b0100_0101;

  typedef struct {
    logic         jf;
    logic [31:0]  npc;
    logic         lu;
    logic         ack;
    logic [7:0]   flags;
    logic [31:0]  onpc;
    fetch_state_t st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic jf, input logic [31:0] npc, input logic lu,
                              input logic ack, input logic [7:0] flags,
                              input logic [31:0] onpc, input fetch_state_t st);
    vec_t v;
    v.jf = jf; v.npc = npc; v.lu = lu; v.ack = ack;
    v.flags = flags; v.onpc = onpc; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic jf, input logic [31:0] npc, input logic lu, input logic ack);
    jump_flag = jf; ex_npc = npc; load_use_hazard = lu; imem_ack = ack;
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] flags,
                          input logic [31:0] onpc, input fetch_state_t st);
    chk({tag, " imem_req"},    32'(imem_req),    32'(flags[7]));
    chk({tag, " pause_flag"},  32'(pause_flag),  32'(flags[6]));
    chk({tag, " jump_out"},    32'(jump_out),    32'(flags[5]));
    chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'(flags[4]));
    chk({tag, " if_id_hold"},  32'(if_id_hold),  32'(flags[3]));
    chk({tag, " if_id_flush"}, 32'(if_id_flush), 32'(flags[2]));
    chk({tag, " id_ex_flush"}, 32'(id_ex_flush), 32'(flags[1]));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'(flags[0]));
    chk({tag, " npc_out"},     npc_out,          onpc);
    chk({tag, " state"},       32'(dbg_state),   32'(st));
  endtask

  initial begin
    // Reset-release cycle and zero-wait stream
    vecs.push_back(mk(0, 0, 0, 1, F_IDLE,  0, IDLE));
    vecs.push_back(mk(0, 0, 0, 1, F_ACK,   0, FETCH));
    vecs.push_back(mk(0, 0, 0, 1, F_ACK,   0, FETCH));
    vecs.push_back(mk(0, 0, 0, 1, F_ACK,   0, FETCH));
    // 3-cycle memory latency, twice
    vecs.push_back(mk(0, 0, 0, 0, F_WAIT,  0, FETCH));
    vecs.push_back(mk(0, 0, 0, 0, F_WAIT,  0, FETCH));
    vecs.push_back(mk(0, 0, 0, 1, F_ACK,   0, FETCH));
    vecs.push_back(mk(0, 0, 0, 0, F_WAIT,  0, FETCH));
    vecs.push_back(mk(0, 0, 0, 0, F_WAIT,  0, FETCH));
    vecs.push_back(mk(0, 0, 0, 1, F_ACK,   0, FETCH));
    // Jump during wait, ack two cycles later
    vecs.push_back(mk(1, 32'h100, 0, 0, F_JWAIT, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 0, F_WAIT,  0, DISCARD));
    vecs.push_back(mk(0, 0, 0, 1, F_DACK,  32'h100, DISCARD));
    // Jump + load-use + ack: jump wins, no stall
    vecs.push_back(mk(1, 32'h200, 1, 1, F_JACK, 32'h200, FETCH));
    // Load-use with ack, then the same PC accepted
    vecs.push_back(mk(0, 0, 1, 1, F_LUACK, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 1, F_ACK,   0, FETCH));
    // Newer jump in DISCARD overwrites target; ack on the last allowed wait cycle
    vecs.push_back(mk(1, 32'h300, 0, 0, F_JWAIT, 0, FETCH));
    vecs.push_back(mk(1, 32'h400, 0, 0, F_JWAIT, 0, DISCARD));
    vecs.push_back(mk(0, 0, 1, 0, F_JWAIT, 0, DISCARD));
    vecs.push_back(mk(0, 0, 0, 1, F_DACK,  32'h400, DISCARD));
    // Jump coincident with ack in DISCARD goes out directly
    vecs.push_back(mk(1, 32'h500, 0, 0, F_JWAIT, 0, FETCH));
    vecs.push_back(mk(1, 32'h600, 0, 1, F_JACK, 32'h600, DISCARD));
    // Timeout: four wait cycles then ERROR, sticky
    vecs.push_back(mk(0, 0, 0, 0, F_WAIT,  0, FETCH));
    vecs.push_back(mk(0, 0, 0, 0, F_WAIT,  0, FETCH));
    vecs.push_back(mk(0, 0, 0, 0, F_WAIT,  0, FETCH));
    vecs.push_back(mk(0, 0, 0, 0, F_WAIT,  0, FETCH));
    vecs.push_back(mk(0, 0, 0, 1, F_ERR,   0, ERROR));
    vecs.push_back(mk(1, 32'h700, 1, 1, F_ERR, 0, ERROR));

    // Clock/reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_outs("reset", F_IDLE, 0, IDLE);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].jf, vecs[i].npc, vecs[i].lu, vecs[i].ack);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].flags, vecs[i].onpc, vecs[i].st);
      @(negedge clk);
    end

    // Asynchronous reset out of ERROR, away from any clock edge
    drive(0, 0, 0, 1);
    #2 rst = 1'b0;
    #1;
    chk_outs("err_async_rst", F_IDLE, 0, IDLE);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outs("late_ack_idle", F_IDLE, 0, IDLE);
    @(negedge clk);
    #1;
    chk_outs("post_rst_fetch", F_ACK, 0, FETCH);

    // Reset while a redirect is pending in DISCARD: target is lost
    @(negedge clk);
    drive(1, 32'h800, 0, 0);
    #1;
    chk_outs("pend_jump", F_JWAIT, 0, FETCH);
    @(negedge clk);
    drive(0, 0, 0, 1);
    #2 rst = 1'b0;
    #1;
    chk_outs("discard_async_rst", F_IDLE, 0, IDLE);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outs("discard_rst_idle", F_IDLE, 0, IDLE);
    @(negedge clk);
    #1;
    chk_outs("no_stale_redirect", F_ACK, 0, FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
